// File: rtl/seq_adder_param_if.sv
// Operand/result bus of the chunked sequential adder: chunk inputs, mode and
// start control going in, full-width result and status flags coming back.
interface seq_adder_param_if #(
  parameter int TOTAL_W = 48,
  parameter int CHUNK_W = 12
);
  logic               start;
  logic               sub;
  logic               chunk_valid;
  logic [CHUNK_W-1:0] inBusA;
  logic [CHUNK_W-1:0] inBusB;
  logic [TOTAL_W-1:0] outBus;
  logic               carry_out;
  logic               overflow;
  logic               busy;
  logic               done;

  modport master (
    output start, sub, chunk_valid, inBusA, inBusB,
    input  outBus, carry_out, overflow, busy, done
  );

  modport slave (
    input  start, sub, chunk_valid, inBusA, inBusB,
    output outBus, carry_out, overflow, busy, done
  );
endinterface

// File: rtl/seq_adder_param.sv
// Multi-chunk sequential adder/subtractor: LSB chunk first, registered carry
// between chunks, result shifted in from the MSB end, carry-out and overflow flags.
module seq_adder_param #(
  parameter int TOTAL_W = 48,
  parameter int CHUNK_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_adder_param_if.slave  bus
);
  localparam int NUM_CHUNKS = TOTAL_W / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if ((TOTAL_W % CHUNK_W) != 0 || NUM_CHUNKS < 2) begin : g_param_err
    $error("seq_adder_param: TOTAL_W must be a multiple of CHUNK_W with at least two chunks");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sub;
  logic               r_carry;
  logic [TOTAL_W-1:0] r_out;
  logic               r_cout;
  logic               r_ovf;
  logic               w_busy;
  logic               w_done;

  logic [CHUNK_W-1:0] w_b;
  logic [CHUNK_W:0]   w_sum;
  logic [CHUNK_W-1:0] w_s;
  logic               w_c;
  logic               w_last;
  logic               w_ovf;

  function automatic logic [CHUNK_W:0] add_chunk(input logic [CHUNK_W-1:0] a,
                                                 input logic [CHUNK_W-1:0] b,
                                                 input logic               cin);
    return {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
  endfunction

  // Carry out of the MSB differs from carry into it exactly on signed overflow.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return c_out ^ (a_msb ^ b_msb ^ s_msb);
  endfunction

  assign w_b    = r_sub ? ~bus.inBusB : bus.inBusB;
  assign w_sum  = add_chunk(bus.inBusA, w_b, r_carry);
  assign w_s    = w_sum[CHUNK_W-1:0];
  assign w_c    = w_sum[CHUNK_W];
  assign w_last = (r_cnt == CNT_W'(NUM_CHUNKS - 1));
  assign w_ovf  = signed_ovf(bus.inBusA[CHUNK_W-1], w_b[CHUNK_W-1], w_s[CHUNK_W-1], w_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (bus.chunk_valid && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_RUN) || (r_state == S_DONE);
    w_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_out   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Carry-in of sub turns ~B into two's-complement -B.
          if (bus.start) begin
            r_sub   <= bus.sub;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.chunk_valid) begin
            r_out   <= {w_s, r_out[TOTAL_W-1:CHUNK_W]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_cout <= w_c;
              r_ovf  <= w_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.outBus    = r_out;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
endmodule

// File: doc/seq_adder_param.md
Name: seq_adder_param

Overview:
Parametrised multi-chunk sequential adder/subtractor. Consumes TOTAL_W-bit operands as NUM_CHUNKS slices of CHUNK_W bits, least significant chunk first, one chunk per accepted cycle. A registered carry propagates between chunks, so the result is a true TOTAL_W-bit sum or difference. Sits behind a narrow operand bus and replaces the fixed 48-bit carry-less sequential adder datapath; it owns its own control FSM, stall handshake, carry-out and signed-overflow flags.

Parameters:
TOTAL_W, 48, full operand/result width in bits
CHUNK_W, 12, chunk width per cycle; TOTAL_W % CHUNK_W must be 0 and NUM_CHUNKS = TOTAL_W/CHUNK_W must be >= 2 (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin an operation; accepted only in IDLE
sub  input  1  mode, sampled with accepted start: 0 = A+B, 1 = A-B
chunk_valid  input  1  inBusA/inBusB carry a valid chunk this cycle
inBusA  input  CHUNK_W  operand A chunk, LSB chunk first
inBusB  input  CHUNK_W  operand B chunk, LSB chunk first
outBus  output  TOTAL_W  result register
carry_out  output  1  final carry (add) / no-borrow (sub); valid while done and held until the next accepted start
overflow  output  1  signed overflow of the full-width result; same validity as carry_out
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result is complete

Behaviour:
- Reset (asynchronous, any state): state=IDLE, outBus=0, carry_out=0, overflow=0, done=0, busy=0, chunk counter=0, mode=add, internal carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 moves to RUN on the next edge.
  - On that edge: latch sub; internal carry = sub; clear counter, outBus, carry_out and overflow.
  - chunk_valid is ignored in IDLE, including in the start cycle.
- RUN, chunk_valid=1 at an edge:
  - b' = sub ? ~inBusB : inBusB.
  - {c, s} = inBusA + b' + carry, computed at CHUNK_W+1 bits.
  - outBus <= {s, outBus[TOTAL_W-1:CHUNK_W]} (shift in at the MSB end). After NUM_CHUNKS shifts, chunk 0 sits at the LSB.
  - carry <= c; counter++.
- RUN, chunk_valid=0: stall; outBus, carry and counter hold.
- Last chunk (counter == NUM_CHUNKS-1 with chunk_valid=1) on the same edge:
  - carry_out <= c.
  - overflow <= c XOR (inBusA[MSB] ^ b'[MSB] ^ s[MSB]), i.e. carry-out XOR carry-into the MSB.
  - state -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. outBus, carry_out and overflow hold until the next accepted start.
- Latency with no stalls: start accepted at edge 0, chunks at edges 1..N, done high in the cycle after edge N. Each stall cycle adds exactly one cycle.
- start while busy (RUN or DONE) is ignored and does not change sub.
- Reset mid-operation aborts immediately. No done pulse is produced, and the partial result is discarded (outBus=0).
- Counter width is clog2(NUM_CHUNKS); it does not wrap because the state leaves RUN at the last chunk.
- Internal carry does not leak between operations: it is reinitialised to sub at every accepted start.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
1. Add with cross-chunk carry: A=0x000000FFFFFF, B=0x000000000001, sub=0, chunks every cycle -> outBus=0x000001000000, carry_out=0, overflow=0, done 5 cycles after start edge.
2. Subtract with borrow: A=0x000000000000, B=0x000000000001, sub=1 -> outBus=0xFFFFFFFFFFFF, carry_out=0 (borrow), overflow=0.
3. Signed overflow: A=0x7FFFFFFFFFFF, B=0x000000000001, add -> outBus=0x800000000000, overflow=1, carry_out=0. Then A=0xFFFFFFFFFFFF, B=0x000000000001 -> outBus=0, carry_out=1, overflow=0.
4. Stall plus ignored start: drop chunk_valid for 3 cycles after chunk 1, and pulse start with sub=1 during RUN -> same result as the unstalled add; done delayed by exactly 3 cycles; mode stays add.
5. Reset mid-operation: assert rst_n=0 asynchronously between edges after 2 chunks -> outBus=0 and busy=0 immediately, no done. A following full operation (A=0x123456789ABC, B=0x111111111111) -> outBus=0x23456789ABCD.
6. Parameter variant TOTAL_W=32, CHUNK_W=8: A=0xFFFFFFFF, B=0x00000001 -> outBus=0x00000000, carry_out=1, done 5 cycles after start edge. Back-to-back operations (start asserted in the IDLE cycle after done) each produce correct results.
